// File: rtl/fib_bcd_calc.sv
// ============================================================================
// Module   : fib_bcd_calc
// Purpose  : BCD index in, Fibonacci F(i) out as BCD. Flags overflow and bad
//            BCD input. Define FIB_BCD_CYC_CNT_EN to add the cyc_cnt port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fib_bcd_calc #(
  parameter int DIG_IN  = 2,
  parameter int DIG_OUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*DIG_IN-1:0]  i_bcd,
  output logic                 ready,
  output logic                 done_tick,
  output logic [4*DIG_OUT-1:0] o_bcd,
  output logic                 ovf,
  output logic                 err
`ifdef FIB_BCD_CYC_CNT_EN
  ,
  output logic [15:0]          cyc_cnt
`endif
);

  localparam int FIB_W = $clog2(10**DIG_OUT);
  localparam int IDX_W = 4*DIG_IN;
  localparam int BCD_W = 4*DIG_OUT;
  localparam int CNT_W = $clog2(FIB_W+1);
  localparam logic [FIB_W:0] MAXV = (FIB_W+1)'(10**DIG_OUT-1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_B2B  = 3'd1,
    S_FIB  = 3'd2,
    S_B2D  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   in_q, in_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FIB_W:0]     t0_q, t0_d, t1_q, t1_d;
  logic [FIB_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   dd_q, dd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   o_bcd_q, o_bcd_d;
  logic               ovf_q, ovf_d, err_q, err_d;

  logic [3:0]         w_digit;
  logic [IDX_W-1:0]   w_idx_mac;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_dd_shift;

  // Index digits are consumed from the top nibble of a left-shifting copy.
  assign w_digit   = in_q[IDX_W-1 -: 4];
  assign w_idx_mac = IDX_W'(idx_q * IDX_W'(10)) + IDX_W'(w_digit);

  for (genvar k = 0; k < DIG_OUT; k++) begin : g_adj
    assign w_adj[4*k +: 4] = (dd_q[4*k +: 4] >= 4'd5) ? dd_q[4*k +: 4] + 4'd3
                                                      : dd_q[4*k +: 4];
  end

  assign w_dd_shift = {w_adj[BCD_W-2:0], bin_q[FIB_W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      in_q    <= '0;
      idx_q   <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      bin_q   <= '0;
      dd_q    <= '0;
      cnt_q   <= '0;
      o_bcd_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      idx_q   <= idx_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      bin_q   <= bin_d;
      dd_q    <= dd_d;
      cnt_q   <= cnt_d;
      o_bcd_q <= o_bcd_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    idx_d   = idx_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    bin_d   = bin_q;
    dd_d    = dd_q;
    cnt_d   = cnt_q;
    o_bcd_d = o_bcd_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_B2B;
          in_d    = i_bcd;
          idx_d   = '0;
          cnt_d   = '0;
          t0_d    = '0;
          t1_d    = (FIB_W+1)'(1);
          o_bcd_d = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_B2B: begin
        if (w_digit > 4'd9) begin
          err_d   = 1'b1;
          o_bcd_d = '0;
          state_d = S_DONE;
        end else begin
          idx_d = w_idx_mac;
          in_d  = in_q << 4;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIG_IN-1)) begin
            state_d = S_FIB;
            cnt_d   = '0;
            t0_d    = '0;
            t1_d    = (FIB_W+1)'(1);
          end
        end
      end
      S_FIB: begin
        // idx_q doubles as the remaining-iteration counter.
        if (idx_q == '0) begin
          state_d = S_B2D;
          bin_d   = t0_q[FIB_W-1:0];
          dd_d    = '0;
          cnt_d   = '0;
        end else if (t1_q > MAXV) begin
          ovf_d   = 1'b1;
          o_bcd_d = {DIG_OUT{4'h9}};
          state_d = S_DONE;
        end else begin
          t0_d  = t1_q;
          t1_d  = t0_q + t1_q;
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_B2D: begin
        dd_d  = w_dd_shift;
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(FIB_W-1)) begin
          o_bcd_d = w_dd_shift;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready     = (state_q == S_IDLE);
  assign done_tick = (state_q == S_DONE);
  assign o_bcd     = o_bcd_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

`ifdef FIB_BCD_CYC_CNT_EN
  logic [15:0] cyc_q;

  // Loaded with 1 on accept so the DONE cycle reads the inclusive count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (start) cyc_q <= 16'd1;
    end else if (state_q != S_DONE && cyc_q != 16'hFFFF) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign cyc_cnt = cyc_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fib_bcd_calc.sv
// Directed self-checking bench for fib_bcd_calc at default parameters.
`default_nettype none

module tb_fib_bcd_calc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  i_bcd = 8'h00;
  logic        ready, done_tick, ovf, err;
  logic [15:0] o_bcd;
`ifdef FIB_BCD_CYC_CNT_EN
  logic [15:0] cyc_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fib_bcd_calc #(.DIG_IN(2), .DIG_OUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .i_bcd     (i_bcd),
    .ready     (ready),
    .done_tick (done_tick),
    .o_bcd     (o_bcd),
    .ovf       (ovf),
    .err       (err)
`ifdef FIB_BCD_CYC_CNT_EN
    ,
    .cyc_cnt   (cyc_cnt)
`endif
  );

  // Pulses start for one edge and returns the number of edges from the
  // accepting edge to the first DONE cycle; ends sampled inside DONE.
  task automatic run_op(input logic [7:0] idx, output int lat);
    @(negedge clk);
    i_bcd = idx;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done_tick !== 1'b1 && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready); end
    n_checks++; if (done_tick !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_tick); end
    n_checks++; if (o_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_obcd got=%h exp=0000", o_bcd); end
    n_checks++; if ({ovf, err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {ovf, err}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fib;
    logic [7:0]  idx [5] = '{8'h10, 8'h00, 8'h01, 8'h07, 8'h20};
    logic [15:0] exp [5] = '{16'h0055, 16'h0000, 16'h0001, 16'h0013, 16'h6765};
    int          elat[5] = '{27, 17, 18, 24, 37};
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(idx[i], lat);
      n_checks++; if (lat !== elat[i]) begin n_fail++; $display("FIB_LAT FAIL idx=%h got=%0d exp=%0d", idx[i], lat, elat[i]); end
      n_checks++; if (o_bcd !== exp[i]) begin n_fail++; $display("FAIL fib_obcd idx=%h got=%h exp=%h", idx[i], o_bcd, exp[i]); end
      n_checks++; if ({ovf, err} !== 2'b00) begin n_fail++; $display("FAIL fib_flags idx=%h got=%b exp=00", idx[i], {ovf, err}); end
`ifdef FIB_BCD_CYC_CNT_EN
      if (idx[i] == 8'h10) begin
        n_checks++; if (cyc_cnt !== 16'd28) begin n_fail++; $display("FAIL cyc_cnt got=%0d exp=28", cyc_cnt); end
      end
`endif
      @(negedge clk);
      n_checks++; if ({done_tick, ready} !== 2'b01) begin n_fail++; $display("FAIL fib_after idx=%h got=%b exp=01", idx[i], {done_tick, ready}); end
    end
    repeat (4) @(negedge clk);
    n_checks++; if (o_bcd !== 16'h6765) begin n_fail++; $display("FAIL hold_obcd got=%h exp=6765", o_bcd); end
  endtask

  task automatic test_overflow;
    logic [7:0] idx [2] = '{8'h21, 8'h99};
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(idx[i], lat);
      n_checks++; if (lat !== 23) begin n_fail++; $display("FAIL ovf_lat idx=%h got=%0d exp=23", idx[i], lat); end
      n_checks++; if (o_bcd !== 16'h9999) begin n_fail++; $display("FAIL ovf_obcd idx=%h got=%h exp=9999", idx[i], o_bcd); end
      n_checks++; if ({ovf, err} !== 2'b10) begin n_fail++; $display("FAIL ovf_flags idx=%h got=%b exp=10", idx[i], {ovf, err}); end
    end
  endtask

  task automatic test_invalid;
    logic [7:0] idx [2] = '{8'h1A, 8'hA1};
    int         elat[2] = '{2, 1};
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(idx[i], lat);
      n_checks++; if (lat !== elat[i]) begin n_fail++; $display("FAIL err_lat idx=%h got=%0d exp=%0d", idx[i], lat, elat[i]); end
      n_checks++; if (o_bcd !== 16'h0000) begin n_fail++; $display("FAIL err_obcd idx=%h got=%h exp=0000", idx[i], o_bcd); end
      n_checks++; if ({ovf, err} !== 2'b01) begin n_fail++; $display("FAIL err_flags idx=%h got=%b exp=01", idx[i], {ovf, err}); end
    end
    run_op(8'h05, lat);
    n_checks++; if ({ovf, err, o_bcd} !== {2'b00, 16'h0005}) begin n_fail++; $display("FAIL err_clear got=%b/%h exp=00/0005", {ovf, err}, o_bcd); end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    i_bcd = 8'h10;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done_tick !== 1'b1 && lat < 300) begin
      if (lat == 5) begin
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready got=%b exp=0", ready); end
        start = 1'b1;
        i_bcd = 8'h05;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++; if (lat !== 27) begin n_fail++; $display("FAIL ign_lat got=%0d exp=27", lat); end
    n_checks++; if (o_bcd !== 16'h0055) begin n_fail++; $display("FAIL ign_obcd got=%h exp=0055", o_bcd); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int ticks;
    @(negedge clk);
    i_bcd = 8'h20;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", ready); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({ready, done_tick, ovf, err} !== 4'b1000) begin n_fail++; $display("FAIL mid_rst_ctl got=%b exp=1000", {ready, done_tick, ovf, err}); end
    n_checks++; if (o_bcd !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_obcd got=%h exp=0000", o_bcd); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ticks = 0;
    repeat (50) begin
      @(negedge clk);
      if (done_tick === 1'b1) ticks++;
    end
    n_checks++; if (ticks !== 0 || ready !== 1'b1) begin n_fail++; $display("FAIL mid_no_done got=%0d/%b exp=0/1", ticks, ready); end
  endtask

  initial begin
    test_reset();
    test_fib();
    test_overflow();
    test_invalid();
    test_ignore_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
